fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  Instruction-fetch front end feeding the instruction port (port A) of the dual-port memory.
//  Issues sequential word reads from a fetch PC and buffers returned {pc, instr} pairs in a FIFO.
//  Decode drains the FIFO. A redirect (branch/jump) flushes the FIFO and restarts fetch.
//  An in-flight memory read cannot be cancelled, so its response is absorbed and discarded.
// PARAMETERS
//  DEPTH     4         FIFO entries; power of two, >= 2
//  RESET_PC  32'h60    fetch PC after reset
// PORTS
//  clk           in   1   clock; all state changes on rising edge
//  rst           in   1   synchronous reset, active-high
//  imem_read     out  1   read request to memory port A; registered
//  imem_address  out  32  word-aligned read address; registered, bits [1:0] always 0
//  imem_resp     in   1   memory response for the current request
//  imem_rdata    in   32  read data; valid when imem_resp=1
//  redirect      in   1   flush the FIFO and restart fetch at redirect_pc
//  redirect_pc   in   32  new fetch PC; bits [1:0] ignored (forced to 0)
//  deq           in   1   decode consumes the head entry; ignored when valid=0 or redirect=1
//  valid         out  1   FIFO non-empty
//  pc_out        out  32  PC of the head entry
//  instr_out     out  32  instruction of the head entry
// BEHAVIOUR
//  Reset: imem_read=0, imem_address=RESET_PC, fetch_pc=RESET_PC, count=0, valid=0, state=IDLE.
//   Reset in any state drops the outstanding request. The memory completes it, and its response is ignored.
//  FSM states: IDLE, BUSY, KILL.
//  IDLE: imem_read=0.
//   - redirect=1: fetch_pc<=redirect_pc; stay in IDLE.
//   - else, if count-after-this-cycle's-deq < DEPTH: imem_address<=fetch_pc, imem_read<=1, go to BUSY.
//  BUSY: hold imem_read=1 and imem_address stable until imem_resp=1.
//   - resp=1, redirect=0: push {imem_address, imem_rdata}; fetch_pc<=fetch_pc+4; imem_read<=0; go to IDLE.
//   - resp=1, redirect=1: discard data; fetch_pc<=redirect_pc; imem_read<=0; go to IDLE.
//   - resp=0, redirect=1: fetch_pc<=redirect_pc; go to KILL (the read stays asserted).
//  KILL: hold imem_read=1 and the old address until resp=1; discard the data; imem_read<=0; go to IDLE.
//   A further redirect in KILL only updates fetch_pc.
//  Request spacing: imem_read is always low for at least 1 cycle after a resp cycle.
//   This prevents the memory from re-answering a stale request.
//  Latency: IDLE->BUSY takes 1 cycle, then memory latency. An entry is visible (valid=1) the cycle after resp.
//   Peak throughput is 1 instruction per 3 cycles with a 1-cycle memory.
//  FIFO:
//   - head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//   - A push and a deq in the same cycle leave count unchanged. A push never occurs when full,
//     because the slot is reserved before the request is issued.
//   - valid = (count!=0). pc_out and instr_out are read from the head entry and are don't-care when valid=0.
//  Redirect: count<=0 and head<=tail in the same cycle; deq in that cycle is ignored.
//   valid=0 in the following cycle.
//  PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
// TESTING
//  1. Reset, 1-cycle memory, deq held high -> reads at 0x60, 0x64, 0x68 in order.
//     Matching pc_out/instr_out appear, imem_read goes low for >=1 cycle between requests.
//  2. deq=0 with DEPTH=4 -> exactly 4 entries pushed, valid stays 1, no 5th request.
//     One deq -> one new request at 0x70.
//  3. Redirect to 0x200 while BUSY with resp delayed 3 cycles -> read held at the old address until resp.
//     Its data is discarded, the next request is at 0x200, and no stale entry ever reaches valid.
//  4. Redirect coincident with resp and deq, FIFO holding 2 -> valid=0 next cycle.
//     Data dropped; the following fetch is at redirect_pc.
//  5. Redirect to 0xFFFF_FFFC -> entries at 0xFFFF_FFFC then 0x0000_0000.
//  6. rst asserted mid-BUSY -> next cycle imem_read=0, valid=0, address=0x60.
//     The late resp is ignored; the first new entry is at pc 0x60.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: sequential word reads into a small {pc, instr} FIFO drained by decode.
// A redirect flushes the FIFO; an in-flight read is waited out and its data dropped.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h60
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq,
    output logic        valid,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, KILL} state_t;

    state_t        state_q;
    logic [31:0]   fetch_pc_q;
    logic          read_q;
    logic [31:0]   addr_q;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic        deq_fire;
    logic        push;
    logic [31:0] target_pc;

    assign target_pc = redirect_pc & ~32'h3;
    assign deq_fire  = deq && (count_q != '0) && !redirect;
    assign push      = (state_q == BUSY) && imem_resp && !redirect;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push)
                tail_d = tail_q + 1'b1;
            if (deq_fire)
                head_d = head_q + 1'b1;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(deq_fire);
        end
    end

    // In IDLE count_d already reflects this cycle's deq, so the slot is reserved before issuing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            read_q     <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            case (state_q)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc_q <= target_pc;
                    end else if (count_d < DEPTH_C) begin
                        addr_q  <= fetch_pc_q;
                        read_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (imem_resp) begin
                        read_q     <= 1'b0;
                        state_q    <= IDLE;
                        fetch_pc_q <= redirect ? target_pc : fetch_pc_q + 32'd4;
                    end else if (redirect) begin
                        fetch_pc_q <= target_pc;
                        state_q    <= KILL;
                    end
                end
                KILL: begin
                    if (redirect)
                        fetch_pc_q <= target_pc;
                    if (imem_resp) begin
                        read_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    read_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= addr_q;
            instr_mem[tail_q] <= imem_rdata;
        end
    end

    assign imem_read    = read_q;
    assign imem_address = addr_q;
    assign valid        = (count_q != '0);
    assign pc_out       = pc_mem[head_q];
    assign instr_out    = instr_mem[head_q];
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: behavioural memory, queue-based reference of the fetch stream, negedge monitor.
module tb_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h60;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        valid;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq(deq), .valid(valid), .pc_out(pc_out), .instr_out(instr_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Memory: answers each request once, mem_lat cycles after first seeing it (0 = random 1..4).
    int          mem_lat;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    initial begin
        imem_resp  = 1'b0;
        imem_rdata = '0;
        mem_busy   = 1'b0;
        mem_cnt    = 0;
        mem_addr   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_resp) begin
                imem_resp = 1'b0;
                mem_busy  = 1'b0;
            end else if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_resp  = 1'b1;
                    imem_rdata = mem_f(mem_addr);
                end
            end else if (imem_read === 1'b1) begin
                mem_busy = 1'b1;
                mem_addr = imem_address;
                mem_cnt  = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4));
            end
        end
    end

    // Reference: expected FIFO contents, next fetch address, and the fate of the open request.
    logic [63:0] mq[$];
    logic [31:0] push_log[$];
    logic [31:0] req_log[$];
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] req_addr = '0;
    logic        req_open = 1'b0;
    logic        req_killed = 1'b0;
    logic        after_rst = 1'b0;
    logic        prev_resp = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                push_log.delete();
                model_pc  = RESET_PC;
                req_open  = 1'b0;
                after_rst = 1'b1;
                prev_resp = 1'b0;
            end else begin
                if (after_rst) begin
                    check("post_rst_read", 32'(imem_read), 32'd0);
                    check("post_rst_valid", 32'(valid), 32'd0);
                    check("post_rst_addr", imem_address, RESET_PC);
                    after_rst = 1'b0;
                end
                check("valid", 32'(valid), 32'(mq.size() != 0));
                if (valid && mq.size() != 0) begin
                    check("pc_out", pc_out, mq[0][63:32]);
                    check("instr_out", instr_out, mq[0][31:0]);
                end
                if (prev_resp)
                    check("spacing", 32'(imem_read), 32'd0);
                if (imem_read && !req_open) begin
                    check("req_addr", imem_address, model_pc);
                    check("req_slot", 32'(mq.size() < DEPTH), 32'd1);
                    req_open   = 1'b1;
                    req_killed = 1'b0;
                    req_addr   = imem_address;
                    req_log.push_back(imem_address);
                end else if (req_open) begin
                    check("hold_read", 32'(imem_read), 32'd1);
                    check("hold_addr", imem_address, req_addr);
                end
                if (deq && !redirect && mq.size() != 0)
                    void'(mq.pop_front());
                if (imem_resp && req_open) begin
                    if (!req_killed && !redirect) begin
                        check("no_overflow", 32'(mq.size() < DEPTH), 32'd1);
                        mq.push_back({req_addr, mem_f(req_addr)});
                        push_log.push_back(req_addr);
                        model_pc = model_pc + 32'd4;
                    end
                    req_open = 1'b0;
                end
                if (redirect) begin
                    mq.delete();
                    push_log.delete();
                    model_pc = redirect_pc & ~32'h3;
                    if (req_open)
                        req_killed = 1'b1;
                end
                prev_resp = imem_resp;
            end
        end
    end

    function automatic logic [31:0] plog(input int i);
        return (i < push_log.size()) ? push_log[i] : 32'hDEAD_0001;
    endfunction

    function automatic logic [31:0] rlog(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_0002;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        int guard;
        rst = 1'b1;
        step();
        guard = 0;
        while ((mem_busy || imem_resp) && guard < 50) begin
            step();
            guard++;
        end
        step();
        rst = 1'b0;
    endtask

    task automatic wait_read();
        int guard;
        guard = 0;
        while (imem_read !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        check("wait_read_timeout", 32'(imem_read), 32'd1);
    endtask

    initial begin
        int guard;
        int n_base;
        rst         = 1'b1;
        deq         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_lat     = 1;

        // Sequential fetch with deq held high
        req_log.delete();
        do_reset();
        deq = 1'b1;
        repeat (20) step();
        check("t1_req0", rlog(0), 32'h60);
        check("t1_req1", rlog(1), 32'h64);
        check("t1_req2", rlog(2), 32'h68);

        // Fill to DEPTH with no deq, then one deq frees exactly one slot
        deq = 1'b0;
        req_log.delete();
        do_reset();
        repeat (40) step();
        check("t2_nreq", 32'(req_log.size()), 32'd4);
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_idle", 32'(imem_read), 32'd0);
        n_base = req_log.size();
        repeat (10) step();
        check("t2_no_5th", 32'(req_log.size()), 32'(n_base));
        deq = 1'b1;
        step();
        deq = 1'b0;
        repeat (10) step();
        check("t2_nreq_after", 32'(req_log.size()), 32'd5);
        check("t2_refill_addr", rlog(4), 32'h70);

        // Redirect while a slow read is outstanding
        req_log.delete();
        mem_lat = 3;
        do_reset();
        deq = 1'b1;
        wait_read();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        repeat (25) step();
        check("t3_first", rlog(0), 32'h60);
        check("t3_after_redir", rlog(1), 32'h200);
        check("t3_first_push", plog(0), 32'h200);

        // Redirect coincident with resp and deq while holding two entries
        mem_lat = 1;
        deq     = 1'b0;
        do_reset();
        guard = 0;
        while (!(imem_resp && mq.size() == 2) && guard < 100) begin
            step();
            guard++;
        end
        check("t4_setup", 32'(imem_resp && mq.size() == 2), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        deq         = 1'b1;
        step();
        redirect = 1'b0;
        deq      = 1'b0;
        check("t4_flush_valid", 32'(valid), 32'd0);
        deq = 1'b1;
        repeat (15) step();
        check("t4_first_push", plog(0), 32'h400);

        // PC wrap at the top of the address space; low bits of redirect_pc ignored
        mem_lat     = 0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        repeat (40) step();
        check("t5_push0", plog(0), 32'hFFFF_FFFC);
        check("t5_push1", plog(1), 32'h0000_0000);

        // Reset during an outstanding read
        mem_lat = 3;
        wait_read();
        step();
        rst = 1'b1;
        step();
        check("t6_read", 32'(imem_read), 32'd0);
        check("t6_valid", 32'(valid), 32'd0);
        check("t6_addr", imem_address, 32'h60);
        guard = 0;
        while ((mem_busy || imem_resp) && guard < 50) begin
            step();
            guard++;
        end
        rst = 1'b0;
        repeat (25) step();
        check("t6_first_push", plog(0), 32'h60);

        // Random traffic against the reference
        mem_lat = 0;
        for (int i = 0; i < 600; i++) begin
            deq      = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom();
            step();
        end
        redirect = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
